// File: rtl/msdap_pkg.sv
// Shared types and sizing for the MSDAP calculation sequencer.
// Command opcodes, sequencer states and the sample-counter increment live here.
package msdap_pkg;

  localparam int RJ_COUNT    = 16;
  localparam int COEFF_DEPTH = 512;
  localparam int DATA_DEPTH  = 256;
  localparam int CPTR_W      = $clog2(COEFF_DEPTH);

  // One extra bit so the pointer can sit at COEFF_DEPTH after the last entry.
  typedef logic [CPTR_W:0] cptr_t;
  localparam cptr_t CPTR_END = cptr_t'(COEFF_DEPTH);

  typedef enum logic [1:0] {
    OP_ADD   = 2'd0,
    OP_SHIFT = 2'd1,
    OP_DONE  = 2'd2
  } cmd_op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RJ_RD,
    S_RJ_CHK,
    S_C_RD,
    S_C_ISSUE,
    S_SHIFT,
    S_FINISH
  } state_t;

  // Samples seen saturates at DATA_DEPTH: beyond that every x(n-k) is valid.
  function automatic logic [8:0] seen_inc(input logic [8:0] s);
    return (s == 9'(DATA_DEPTH)) ? s : s + 9'd1;
  endfunction

endpackage

// File: rtl/calc_sequencer_if.sv
// Command channel from the sequencer to the accumulate-and-shift datapath.
// A command transfers in a cycle where cmd_valid and cmd_ready are both 1; while
// cmd_valid=1 and cmd_ready=0 the master holds every command field unchanged.
interface calc_sequencer_if;
  import msdap_pkg::*;

  logic       cmd_valid;
  logic       cmd_ready;
  cmd_op_t    cmd_op;
  logic       cmd_sign;
  logic       cmd_zero;
  logic [7:0] cmd_data_addr;

  modport master (
    output cmd_valid, cmd_op, cmd_sign, cmd_zero, cmd_data_addr,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_sign, cmd_zero, cmd_data_addr,
    output cmd_ready
  );

endinterface

// File: rtl/msdap_term_addr.sv
// Data-memory address of x(n-k) in the circular buffer, plus a flag for terms
// that refer to samples older than the first one written since the last clear.
module msdap_term_addr
  import msdap_pkg::*;
(
  input  logic [7:0] n,
  input  logic [7:0] k,
  input  logic [8:0] samples_seen,
  output logic [7:0] data_addr,
  output logic       zero
);

  assign data_addr = n - k;
  assign zero      = ({1'b0, k} >= samples_seen);

endmodule

// File: rtl/calc_sequencer.sv
// Walks the rj groups and coefficients for one output sample and emits the
// ADD / SHIFT / DONE command stream for the accumulate-and-shift datapath.
module calc_sequencer
  import msdap_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [7:0]           sample_idx,
  input  logic                 clear,
  output logic [3:0]           rj_addr,
  input  logic [15:0]          rj_data,
  output logic [8:0]           coeff_addr,
  input  logic [8:0]           coeff_data,
  calc_sequencer_if.master     cmd,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_err,
  output logic                 overrun,
  output state_t               dbg_state
);

  state_t      state_q, state_d;
  logic [7:0]  n_q, n_d;
  logic [8:0]  seen_q, seen_d;
  logic [3:0]  rj_idx_q, rj_idx_d;
  cptr_t       cptr_q, cptr_d;
  logic [15:0] remaining_q, remaining_d;
  logic        cfg_err_q, cfg_err_d;
  logic        overrun_q, overrun_d;
  logic        clr_pend_q, clr_pend_d;
  logic        done_q, done_d;

  logic [7:0]  term_addr;
  logic        term_zero;

  msdap_term_addr u_term_addr (
    .n            (n_q),
    .k            (coeff_data[7:0]),
    .samples_seen (seen_q),
    .data_addr    (term_addr),
    .zero         (term_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      seen_q      <= '0;
      rj_idx_q    <= '0;
      cptr_q      <= '0;
      remaining_q <= '0;
      cfg_err_q   <= 1'b0;
      overrun_q   <= 1'b0;
      clr_pend_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      seen_q      <= seen_d;
      rj_idx_q    <= rj_idx_d;
      cptr_q      <= cptr_d;
      remaining_q <= remaining_d;
      cfg_err_q   <= cfg_err_d;
      overrun_q   <= overrun_d;
      clr_pend_q  <= clr_pend_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    n_d               = n_q;
    seen_d            = seen_q;
    rj_idx_d          = rj_idx_q;
    cptr_d            = cptr_q;
    remaining_d       = remaining_q;
    cfg_err_d         = cfg_err_q;
    overrun_d         = overrun_q;
    clr_pend_d        = clr_pend_q;
    done_d            = 1'b0;
    rj_addr           = '0;
    coeff_addr        = '0;
    cmd.cmd_valid     = 1'b0;
    cmd.cmd_op        = OP_ADD;
    cmd.cmd_sign      = 1'b0;
    cmd.cmd_zero      = 1'b0;
    cmd.cmd_data_addr = '0;

    if (state_q != S_IDLE) begin
      if (start) overrun_d = 1'b1;
      if (clear) clr_pend_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        // A held or fresh clear takes effect before a coincident start.
        if (clear || clr_pend_q) begin
          seen_d     = '0;
          clr_pend_d = 1'b0;
        end
        if (start) begin
          n_d      = sample_idx;
          seen_d   = (clear || clr_pend_q) ? 9'd1 : seen_inc(seen_q);
          rj_idx_d = '0;
          cptr_d   = '0;
          state_d  = S_RJ_RD;
        end
      end
      S_RJ_RD: begin
        rj_addr = rj_idx_q;
        state_d = S_RJ_CHK;
      end
      S_RJ_CHK: begin
        remaining_d = rj_data;
        state_d     = (rj_data == '0 || cptr_q == CPTR_END) ? S_SHIFT : S_C_RD;
      end
      S_C_RD: begin
        coeff_addr = cptr_q[CPTR_W-1:0];
        state_d    = S_C_ISSUE;
      end
      S_C_ISSUE: begin
        // Address stays on the bus so coeff_data is stable through a stall.
        coeff_addr        = cptr_q[CPTR_W-1:0];
        cmd.cmd_valid     = 1'b1;
        cmd.cmd_op        = OP_ADD;
        cmd.cmd_sign      = coeff_data[8];
        cmd.cmd_zero      = term_zero;
        cmd.cmd_data_addr = term_addr;
        if (cmd.cmd_ready) begin
          cptr_d      = cptr_q + 1'b1;
          remaining_d = remaining_q - 16'd1;
          if (remaining_q == 16'd1) begin
            state_d = S_SHIFT;
          end else if (cptr_q + 1'b1 == CPTR_END) begin
            cfg_err_d = 1'b1;
            state_d   = S_SHIFT;
          end else begin
            state_d = S_C_RD;
          end
        end
      end
      S_SHIFT: begin
        cmd.cmd_valid = 1'b1;
        cmd.cmd_op    = OP_SHIFT;
        if (cmd.cmd_ready) begin
          if (rj_idx_q == 4'(RJ_COUNT - 1)) begin
            state_d = S_FINISH;
          end else begin
            rj_idx_d = rj_idx_q + 4'd1;
            state_d  = S_RJ_RD;
          end
        end
      end
      S_FINISH: begin
        cmd.cmd_valid = 1'b1;
        cmd.cmd_op    = OP_DONE;
        if (cmd.cmd_ready) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;
  assign overrun   = overrun_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer: models the rj/coefficient memories and
// checks the command stream, cycle timing and sticky flags against hand values.
module tb_calc_sequencer;
  import msdap_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  sample_idx;
  logic        clear;
  logic [3:0]  rj_addr;
  logic [15:0] rj_data;
  logic [8:0]  coeff_addr;
  logic [8:0]  coeff_data;
  logic        busy, done, cfg_err, overrun;
  state_t      dbg_state;

  calc_sequencer_if cif();

  calc_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .sample_idx (sample_idx),
    .clear      (clear),
    .rj_addr    (rj_addr),
    .rj_data    (rj_data),
    .coeff_addr (coeff_addr),
    .coeff_data (coeff_data),
    .cmd        (cif),
    .busy       (busy),
    .done       (done),
    .cfg_err    (cfg_err),
    .overrun    (overrun),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous-read memory models
  logic [15:0] rj_mem [16];
  logic [8:0]  coeff_mem [512];
  always @(posedge clk) begin
    rj_data    <= rj_mem[rj_addr];
    coeff_data <= coeff_mem[coeff_addr];
  end

  // scoreboard
  int checks   = 0;
  int failures = 0;
  logic [11:0] exp_q[$];
  logic [11:0] got_q[$];
  int fin_cyc, done_cyc, stalls;

  typedef struct {
    bit         clr;
    logic [7:0] n;
    logic       sign;
    logic [7:0] k;
    logic [7:0] exp_addr;
    logic       exp_zero;
  } vec_t;
  vec_t vecs [6];

  function automatic logic [11:0] pk(input logic [1:0] op, input logic s,
                                     input logic z, input logic [7:0] a);
    return {op, s, z, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic clear_mems();
    for (int i = 0; i < 16; i++) rj_mem[i] = '0;
    for (int i = 0; i < 512; i++) coeff_mem[i] = '0;
  endtask

  task automatic push_shifts(input int cnt);
    for (int i = 0; i < cnt; i++) exp_q.push_back(pk(2'(OP_SHIFT), 1'b0, 1'b0, 8'd0));
  endtask

  task automatic cmp_cmds(input string name);
    int m;
    chk($sformatf("%s_len", name), got_q.size(), exp_q.size());
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) chk($sformatf("%s[%0d]", name, i), got_q[i], exp_q[i]);
  endtask

  // driver + monitor for one computation; entered and left at posedge+1 in IDLE
  task automatic run(input logic [7:0] n, input bit clr, input bit stall,
                     input int clear_at, input int start_at, input int max_cyc);
    logic [11:0] cur, held;
    bit held_valid;
    got_q.delete();
    fin_cyc = -1; done_cyc = -1; stalls = 0; held_valid = 0; held = '0;
    start = 1'b1; sample_idx = n; clear = clr; cif.cmd_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    for (int c = 1; c <= max_cyc; c++) begin
      cif.cmd_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      start = (c == start_at);
      clear = (c == clear_at);
      @(negedge clk);
      if (c == 1) begin
        chk("busy_cycle1", busy, 1'b1);
        chk("state_cycle1", dbg_state, S_RJ_RD);
      end
      cur = pk(cif.cmd_op, cif.cmd_sign, cif.cmd_zero, cif.cmd_data_addr);
      if (held_valid) begin
        chk("stall_valid_held", cif.cmd_valid, 1'b1);
        chk("stall_fields_held", cur, held);
      end
      held_valid = 0;
      if (cif.cmd_valid && !cif.cmd_ready) begin
        stalls++; held = cur; held_valid = 1;
      end
      if (cif.cmd_valid && cif.cmd_ready) begin
        got_q.push_back(cur);
        if (cif.cmd_op == OP_DONE) fin_cyc = c;
      end
      if (done) begin
        done_cyc = c;
        chk("busy_at_done", busy, 1'b0);
        @(posedge clk); #1;
        start = 1'b0; clear = 1'b0; cif.cmd_ready = 1'b1;
        return;
      end
      @(posedge clk); #1;
    end
    checks++; failures++;
    $display("FAIL timeout no done within %0d cycles", max_cyc);
    start = 1'b0; clear = 1'b0; cif.cmd_ready = 1'b1;
  endtask

  initial begin : main
    int nadd, nshift, ndone, dcount;
    bit found;

    vecs[0] = '{clr:1, n:8'd0,   sign:0, k:8'd0,   exp_addr:8'd0,   exp_zero:0};
    vecs[1] = '{clr:0, n:8'd1,   sign:1, k:8'd1,   exp_addr:8'd0,   exp_zero:0};
    vecs[2] = '{clr:0, n:8'd2,   sign:0, k:8'd3,   exp_addr:8'd255, exp_zero:1};
    vecs[3] = '{clr:1, n:8'd5,   sign:1, k:8'd1,   exp_addr:8'd4,   exp_zero:1};
    vecs[4] = '{clr:0, n:8'd200, sign:0, k:8'd255, exp_addr:8'd201, exp_zero:1};
    vecs[5] = '{clr:0, n:8'd7,   sign:1, k:8'd1,   exp_addr:8'd6,   exp_zero:0};

    reset = 1'b1; start = 1'b0; clear = 1'b0; sample_idx = '0; cif.cmd_ready = 1'b0;
    clear_mems();
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_state", dbg_state, S_IDLE);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_valid", cif.cmd_valid, 1'b0);
    chk("rst_op", cif.cmd_op, 2'd0);
    chk("rst_rj_addr", rj_addr, 4'd0);
    chk("rst_coeff_addr", coeff_addr, 9'd0);
    chk("rst_cfg_err", cfg_err, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;

    // all groups empty
    run(8'd0, 1'b1, 1'b0, -1, -1, 200);
    exp_q.delete(); push_shifts(16); exp_q.push_back(pk(2'(OP_DONE), 1'b0, 1'b0, 8'd0));
    cmp_cmds("allzero");
    chk("allzero_finish", fin_cyc, 49);
    chk("allzero_done", done_cyc, 50);
    @(negedge clk);
    chk("done_one_cycle", done, 1'b0);
    @(posedge clk); #1;

    // two terms in group 0, one before the first sample
    clear_mems();
    rj_mem[0] = 16'd2; coeff_mem[0] = {1'b0, 8'd0}; coeff_mem[1] = {1'b1, 8'd3};
    run(8'd10, 1'b1, 1'b0, -1, -1, 200);
    exp_q.delete();
    exp_q.push_back(pk(2'(OP_ADD), 1'b0, 1'b0, 8'd10));
    exp_q.push_back(pk(2'(OP_ADD), 1'b1, 1'b1, 8'd7));
    push_shifts(16); exp_q.push_back(pk(2'(OP_DONE), 1'b0, 1'b0, 8'd0));
    cmp_cmds("two_terms");
    chk("two_terms_finish", fin_cyc, 53);

    // single-term table
    clear_mems();
    rj_mem[0] = 16'd1;
    for (int v = 0; v < 6; v++) begin
      coeff_mem[0] = {vecs[v].sign, vecs[v].k};
      run(vecs[v].n, vecs[v].clr, 1'b0, -1, -1, 200);
      exp_q.delete();
      exp_q.push_back(pk(2'(OP_ADD), vecs[v].sign, vecs[v].exp_zero, vecs[v].exp_addr));
      push_shifts(16); exp_q.push_back(pk(2'(OP_DONE), 1'b0, 1'b0, 8'd0));
      cmp_cmds($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_finish", v), fin_cyc, 51);
      chk($sformatf("vec%0d_done", v), done_cyc, 52);
    end

    // saturation of the sample counter, with a clear arriving mid-run
    clear_mems();
    for (int i = 0; i < 299; i++) run(8'(i), (i == 0), 1'b0, -1, -1, 200);
    rj_mem[0] = 16'd2; coeff_mem[0] = {1'b0, 8'd5}; coeff_mem[1] = {1'b1, 8'd255};
    run(8'd2, 1'b0, 1'b0, 10, -1, 200);
    exp_q.delete();
    exp_q.push_back(pk(2'(OP_ADD), 1'b0, 1'b0, 8'd253));
    exp_q.push_back(pk(2'(OP_ADD), 1'b1, 1'b0, 8'd3));
    push_shifts(16); exp_q.push_back(pk(2'(OP_DONE), 1'b0, 1'b0, 8'd0));
    cmp_cmds("sat300");
    clear_mems();
    rj_mem[0] = 16'd1; coeff_mem[0] = {1'b0, 8'd1};
    run(8'd9, 1'b0, 1'b0, -1, -1, 200);
    exp_q.delete();
    exp_q.push_back(pk(2'(OP_ADD), 1'b0, 1'b1, 8'd8));
    push_shifts(16); exp_q.push_back(pk(2'(OP_DONE), 1'b0, 1'b0, 8'd0));
    cmp_cmds("pending_clear");

    // random backpressure
    clear_mems();
    rj_mem[0] = 16'd3; rj_mem[5] = 16'd2;
    coeff_mem[0] = {1'b0, 8'd1}; coeff_mem[1] = {1'b1, 8'd2}; coeff_mem[2] = {1'b0, 8'd0};
    coeff_mem[3] = {1'b1, 8'd4}; coeff_mem[4] = {1'b0, 8'd9};
    run(8'd20, 1'b1, 1'b1, -1, -1, 400);
    exp_q.delete();
    exp_q.push_back(pk(2'(OP_ADD), 1'b0, 1'b1, 8'd19));
    exp_q.push_back(pk(2'(OP_ADD), 1'b1, 1'b1, 8'd18));
    exp_q.push_back(pk(2'(OP_ADD), 1'b0, 1'b0, 8'd20));
    push_shifts(5);
    exp_q.push_back(pk(2'(OP_ADD), 1'b1, 1'b1, 8'd16));
    exp_q.push_back(pk(2'(OP_ADD), 1'b0, 1'b1, 8'd11));
    push_shifts(11); exp_q.push_back(pk(2'(OP_DONE), 1'b0, 1'b0, 8'd0));
    cmp_cmds("stall");
    chk("stall_finish", fin_cyc, 59 + stalls);
    chk("stall_done", done_cyc, 60 + stalls);

    // coefficient memory overflow
    chk("cfg_err_before", cfg_err, 1'b0);
    clear_mems();
    rj_mem[0] = 16'd300; rj_mem[1] = 16'd300;
    for (int i = 0; i < 512; i++) coeff_mem[i] = {1'(i), 8'(i)};
    run(8'd50, 1'b0, 1'b0, -1, -1, 3000);
    nadd = 0; nshift = 0; ndone = 0;
    foreach (got_q[i]) begin
      if (got_q[i][11:10] == 2'(OP_ADD))   nadd++;
      if (got_q[i][11:10] == 2'(OP_SHIFT)) nshift++;
      if (got_q[i][11:10] == 2'(OP_DONE))  ndone++;
    end
    chk("cfg_adds", nadd, 512);
    chk("cfg_shifts", nshift, 16);
    chk("cfg_dones", ndone, 1);
    chk("cfg_err_set", cfg_err, 1'b1);
    chk("cfg_finish", fin_cyc, 1073);

    // start while busy
    chk("overrun_before", overrun, 1'b0);
    clear_mems();
    run(8'd33, 1'b0, 1'b0, -1, 10, 200);
    exp_q.delete(); push_shifts(16); exp_q.push_back(pk(2'(OP_DONE), 1'b0, 1'b0, 8'd0));
    cmp_cmds("overrun_run");
    chk("overrun_finish", fin_cyc, 49);
    chk("overrun_set", overrun, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    @(negedge clk);
    chk("overrun_no_rerun", busy, 1'b0);
    @(posedge clk); #1;

    // reset in the middle of an ADD stall
    clear_mems();
    rj_mem[0] = 16'd2; coeff_mem[0] = {1'b1, 8'd1};
    start = 1'b1; sample_idx = 8'd3; cif.cmd_ready = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    start = 1'b0;
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (dbg_state == S_C_ISSUE) found = 1;
      @(posedge clk); #1;
    end
    chk("reach_c_issue", found, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_state", dbg_state, S_IDLE);
    chk("mid_rst_valid", cif.cmd_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_coeff_addr", coeff_addr, 9'd0);
    chk("mid_rst_sign", cif.cmd_sign, 1'b0);
    chk("mid_rst_cfg_err", cfg_err, 1'b0);
    chk("mid_rst_overrun", overrun, 1'b0);
    cif.cmd_ready = 1'b1;
    dcount = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (done || cif.cmd_valid) dcount++;
    end
    chk("mid_rst_no_done", dcount, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
